// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the external bus arbiter: transfer sizes and
// arbiter grant states.
package bus_arbiter_pkg;

    localparam logic [1:0] SIZE_NONE = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_watchdog.sv
// Per-transfer watchdog: counts granted cycles without an acknowledge and
// flags expiry in the cycle where the count reaches TIMEOUT-1.
module bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic i_clear,   // no legal grant in progress, or the grant ends this edge
    input  logic i_active,  // a legal transfer is on the bus this cycle
    input  logic i_ack,
    output logic o_expire
);

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_wd;

    // Count unacknowledged granted cycles; restart for every new grant.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)
            r_wd <= '0;
        else if (i_clear)
            r_wd <= '0;
        else if (i_active && !i_ack)
            r_wd <= r_wd + 8'd1;
    end

    // An ack in the expiry cycle completes the transfer normally.
    assign o_expire = i_active && !i_ack && (r_wd == WD_LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the 16-bit external bus between the fetch
// (I) and load/store (D) masters, one transfer per grant, with a watchdog
// abort for transfers the bus never acknowledges.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [63:0] i_adr_i,
    input  logic [1:0]  i_size_i,
    output logic        i_ack_o,
    output logic        i_err_o,
    input  logic [63:0] d_adr_i,
    input  logic [1:0]  d_size_i,
    input  logic        d_we_i,
    input  logic [15:0] d_dat_i,
    output logic        d_ack_o,
    output logic        d_err_o,
    output logic [63:0] adr_o,
    output logic [1:0]  size_o,
    output logic        we_o,
    output logic [15:0] dat_o,
    input  logic        ack_i,
    output logic        gnt_d_o
);

    arb_state_e r_st;
    arb_state_e w_next;
    logic       r_last_d;

    logic [1:0] w_gsize;
    logic       w_i_req, w_d_req;
    logic       w_granted, w_legal, w_illegal, w_withdraw;
    logic       w_ack_ok, w_expire, w_err, w_end, w_last_eff, w_wd_clear;

    assign w_i_req = (i_size_i != SIZE_NONE);
    assign w_d_req = (d_size_i != SIZE_NONE);

    // Route the granted master onto the bus; IDLE drives all zeros.
    always_comb begin
        w_gsize = SIZE_NONE;
        adr_o   = '0;
        we_o    = 1'b0;
        dat_o   = '0;
        case (r_st)
            ST_GNT_I: begin
                w_gsize = i_size_i;
                adr_o   = i_adr_i;
            end
            ST_GNT_D: begin
                w_gsize = d_size_i;
                adr_o   = d_adr_i;
                we_o    = d_we_i;
                dat_o   = d_dat_i;
            end
            default: ;
        endcase
    end

    assign w_granted  = (r_st != ST_IDLE);
    assign w_legal    = w_granted && ((w_gsize == SIZE_BYTE) || (w_gsize == SIZE_HALF));
    assign w_illegal  = w_granted && (w_gsize == SIZE_ILL);
    assign w_withdraw = w_granted && (w_gsize == SIZE_NONE);

    // Illegal size never reaches the bus, so the slave cannot see it.
    assign size_o = w_legal ? w_gsize : SIZE_NONE;

    // Only a transfer actually on the bus can be acknowledged.
    assign w_ack_ok = w_legal && ack_i;
    assign w_err    = w_illegal || w_expire;
    assign w_end    = w_ack_ok || w_err || w_withdraw;

    assign i_ack_o = w_ack_ok && (r_st == ST_GNT_I);
    assign d_ack_o = w_ack_ok && (r_st == ST_GNT_D);
    assign i_err_o = w_err    && (r_st == ST_GNT_I);
    assign d_err_o = w_err    && (r_st == ST_GNT_D);
    assign gnt_d_o = (r_st == ST_GNT_D);

    assign w_wd_clear = !w_legal || w_end;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .i_clear  (w_wd_clear),
        .i_active (w_legal),
        .i_ack    (ack_i),
        .o_expire (w_expire)
    );

    // On a completion edge the grant just finishing counts as last served,
    // so a back-to-back re-grant already alternates.
    assign w_last_eff = w_end ? (r_st == ST_GNT_D) : r_last_d;

    // Round-robin choice from the requests present this edge.
    always_comb begin
        w_next = ST_IDLE;
        if (w_i_req && w_d_req)
            w_next = w_last_eff ? ST_GNT_I : ST_GNT_D;
        else if (w_d_req)
            w_next = ST_GNT_D;
        else if (w_i_req)
            w_next = ST_GNT_I;
    end

    // Grant FSM: re-arbitrate from IDLE or on the edge a grant ends.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_st     <= ST_IDLE;
            r_last_d <= 1'b1;
        end else if ((r_st == ST_IDLE) || w_end) begin
            if (w_end)
                r_last_d <= (r_st == ST_GNT_D);
            r_st <= w_next;
        end
    end

endmodule
